line_mem_bridge: RTL and testbench

Downstream stage of the cache: terminates the cache's master (miss) interface and converts whole-line requests into 64-bit beats on a simple memory port. It acknowledges each line request immediately with a deferred-miss handle, queues it, then writes strobed beats, reads the line back, and returns the line by calling back with the handle. It sits between the last cache level and the memory model or controller.

---
 rtl/mem_pkg.sv | 22 ++
 rtl/line_mem_bridge_if.sv | 23 ++
 rtl/firstk.sv | 22 ++
 rtl/idx_fifo.sv | 54 +++++
 rtl/line_mem_bridge.sv | 214 +++++++++++++++++++++
 tb/tb_line_mem_bridge.sv | 336 +++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the line-to-beat memory bridge: beat geometry,
// completion handle base, FSM state encoding and the debug view.
package mem_pkg;

    localparam int BEAT_BYTES = 8;
    localparam logic [7:0] HANDLE_BASE = 8'h80;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Debug view: FSM state plus the request being serviced.
    typedef struct packed {
        state_t     state;
        logic [7:0] rqst;
        logic [7:0] handle;
    } dbg_t;

endpackage

// File: rtl/line_mem_bridge_if.sv
// Upstream line-request bus: the cache drives requests (master), the bridge
// acknowledges and later completes them (slave).
interface line_mem_bridge_if #(parameter int blk = 64);

    logic [7:0]       s_rqst;
    logic [blk-1:0]   s_strb;
    logic [63:0]      s_addr;
    logic [blk*8-1:0] s_wdat;
    logic [7:0]       s_resp;
    logic [7:0]       s_miss;
    logic [blk*8-1:0] s_rdat;

    modport master (
        output s_rqst, s_strb, s_addr, s_wdat,
        input  s_resp, s_miss, s_rdat
    );

    modport slave (
        input  s_rqst, s_strb, s_addr, s_wdat,
        output s_resp, s_miss, s_rdat
    );

endinterface

// File: rtl/firstk.sv
// Selects the lowest k set bits of a vector as a mask.
module firstk #(
    parameter int width = 4,
    parameter int k     = 1
) (
    input  logic [width-1:0] req,
    output logic [width-1:0] sel
);

    always_comb begin
        int cnt;
        sel = '0;
        cnt = 0;
        for (int i = 0; i < width; i++) begin
            if (req[i] && cnt < k) begin
                sel[i] = 1'b1;
                cnt++;
            end
        end
    end

endmodule

// File: rtl/idx_fifo.sv
// Small circular FIFO of slot indices; records the order requests were accepted.
module idx_fifo #(
    parameter int depth = 4,
    parameter int width = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [width-1:0] din,
    input  logic             pop,
    output logic [width-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int PW = (depth > 1) ? $clog2(depth) : 1;

    logic [width-1:0] buf_q [depth];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(depth - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(depth));
    assign head    = buf_q[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                buf_q[wr_ptr] <= din;
                wr_ptr        <= wrap_inc(wr_ptr);
            end
            if (do_pop) rd_ptr <= wrap_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/line_mem_bridge.sv
// Terminates cache line misses: acknowledges with a slot handle, then writes
// strobed beats, reads the line back and completes with the merged line.
import mem_pkg::*;

module line_mem_bridge #(
    parameter int blk   = 64,
    parameter int slots = 4
) (
    input  logic        clk,
    input  logic        rst,
    line_mem_bridge_if.slave s,
    output logic        mem_req,
    input  logic        mem_rdy,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdat,
    output logic [7:0]  mem_wstrb,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdat,
    output dbg_t        dbg
);

    localparam int beats = blk / BEAT_BYTES;
    localparam int SW    = (slots > 1) ? $clog2(slots) : 1;
    localparam int BW    = $clog2(beats + 1);

    logic [slots-1:0] slot_vld;
    logic [7:0]       slot_rqst [slots];
    logic [blk-1:0]   slot_strb [slots];
    logic [63:0]      slot_base [slots];
    logic [blk*8-1:0] slot_wdat [slots];

    state_t           state;
    logic [SW-1:0]    cur;
    logic [BW-1:0]    wi;
    logic [BW-1:0]    ic;
    logic [BW-1:0]    rc;
    logic [blk*8-1:0] line_buf;

    logic [slots-1:0] free_oh;
    logic [SW-1:0]    free_idx;
    logic             ack;
    logic [SW-1:0]    head;
    logic             fifo_empty;
    logic             fifo_full;

    firstk #(.width(slots), .k(1)) u_firstk (
        .req (~slot_vld),
        .sel (free_oh)
    );

    always_comb begin
        free_idx = '0;
        for (int i = 0; i < slots; i++) begin
            if (free_oh[i]) free_idx = SW'(i);
        end
    end

    // A completion owns the response bus, so acknowledges wait while in RESP.
    assign ack = !rst && (s.s_rqst != 8'd0) && (|free_oh) && !fifo_full
                 && (state != RESP);

    always_comb begin
        s.s_resp = 8'd0;
        s.s_miss = 8'd0;
        s.s_rdat = '0;
        if (state == RESP) begin
            s.s_resp = HANDLE_BASE | 8'(cur);
            s.s_rdat = line_buf;
        end else if (ack) begin
            s.s_resp = s.s_rqst;
            s.s_miss = HANDLE_BASE | 8'(free_idx);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_vld <= '0;
        end else begin
            if (ack)           slot_vld[free_idx] <= 1'b1;
            if (state == RESP) slot_vld[cur]      <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (ack) begin
            slot_rqst[free_idx] <= s.s_rqst;
            slot_strb[free_idx] <= s.s_strb;
            slot_base[free_idx] <= s.s_addr & ~64'(blk - 1);
            slot_wdat[free_idx] <= s.s_wdat;
        end
    end

    idx_fifo #(.depth(slots), .width(SW)) u_order (
        .clk   (clk),
        .rst   (rst),
        .push  (ack),
        .din   (free_idx),
        .pop   (state == RESP),
        .head  (head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Next write beat with a non-zero strobe slice, searched from 'from'.
    logic [SW-1:0]    sel_idx;
    logic [blk-1:0]   sel_strb;
    logic [blk*8-1:0] sel_wdat;
    logic [63:0]      sel_base;
    logic [BW-1:0]    from;
    logic             nxt_found;
    logic [BW-1:0]    nxt_idx;

    always_comb begin
        sel_idx   = (state == IDLE) ? head : cur;
        sel_strb  = slot_strb[sel_idx];
        sel_wdat  = slot_wdat[sel_idx];
        sel_base  = slot_base[sel_idx];
        from      = (state == IDLE) ? '0 : wi + BW'(1);
        nxt_found = 1'b0;
        nxt_idx   = '0;
        for (int i = beats - 1; i >= 0; i--) begin
            if (int'(from) <= i && sel_strb[i*8 +: 8] != 8'd0) begin
                nxt_found = 1'b1;
                nxt_idx   = BW'(i);
            end
        end
    end

    // Memory port: a beat transfers when mem_req & mem_rdy; while mem_req is
    // high and mem_rdy low, every mem_* output holds its value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur       <= '0;
            wi        <= '0;
            ic        <= '0;
            rc        <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdat  <= '0;
            mem_wstrb <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        cur     <= head;
                        ic      <= '0;
                        rc      <= '0;
                        mem_req <= 1'b1;
                        if (nxt_found) begin
                            state     <= WRITE;
                            wi        <= nxt_idx;
                            mem_we    <= 1'b1;
                            mem_addr  <= sel_base + (64'(nxt_idx) << 3);
                            mem_wdat  <= sel_wdat[nxt_idx*64 +: 64];
                            mem_wstrb <= sel_strb[nxt_idx*8 +: 8];
                        end else begin
                            state     <= READ;
                            mem_we    <= 1'b0;
                            mem_addr  <= sel_base;
                            mem_wdat  <= '0;
                            mem_wstrb <= '0;
                        end
                    end
                end
                WRITE: begin
                    if (mem_rdy) begin
                        if (nxt_found) begin
                            wi        <= nxt_idx;
                            mem_addr  <= sel_base + (64'(nxt_idx) << 3);
                            mem_wdat  <= sel_wdat[nxt_idx*64 +: 64];
                            mem_wstrb <= sel_strb[nxt_idx*8 +: 8];
                        end else begin
                            state     <= READ;
                            mem_we    <= 1'b0;
                            mem_addr  <= sel_base;
                            mem_wdat  <= '0;
                            mem_wstrb <= '0;
                        end
                    end
                end
                READ: begin
                    if (mem_req && mem_rdy) begin
                        if (ic == BW'(beats - 1)) begin
                            mem_req <= 1'b0;
                        end else begin
                            ic       <= ic + BW'(1);
                            mem_addr <= mem_addr + 64'd8;
                        end
                    end
                    if (mem_rvalid) begin
                        rc <= rc + BW'(1);
                        if (rc == BW'(beats - 1)) state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == READ && mem_rvalid) line_buf[rc*64 +: 64] <= mem_rdat;
    end

    assign dbg.state  = state;
    assign dbg.rqst   = slot_rqst[cur];
    assign dbg.handle = HANDLE_BASE | 8'(cur);

endmodule

// File: tb/tb_line_mem_bridge.sv
// Directed bench for line_mem_bridge with a latency-L memory model and a
// beat scoreboard fed from an expected queue.
module tb_line_mem_bridge;
    import mem_pkg::*;

    localparam int BLK = 64;
    localparam int L   = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    line_mem_bridge_if #(.blk(BLK)) bus ();

    logic        mem_req, mem_rdy, mem_we, mem_rvalid;
    logic [63:0] mem_addr, mem_wdat, mem_rdat;
    logic [7:0]  mem_wstrb;
    dbg_t        dbg;

    logic        model_v = 1'b0;
    logic [63:0] model_d = '0;
    logic        inj_v   = 1'b0;
    logic [63:0] inj_d   = '0;
    assign mem_rvalid = model_v | inj_v;
    assign mem_rdat   = inj_v ? inj_d : model_d;

    line_mem_bridge #(.blk(BLK), .slots(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .s          (bus.slave),
        .mem_req    (mem_req),
        .mem_rdy    (mem_rdy),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdat   (mem_wdat),
        .mem_wstrb  (mem_wstrb),
        .mem_rvalid (mem_rvalid),
        .mem_rdat   (mem_rdat),
        .dbg        (dbg)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [72:0] exp_q[$];
    logic [63:0] exp_wd_q[$];

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- memory model ----------------
    logic [63:0] mem_model [logic [63:0]];
    typedef struct { int due; logic [63:0] d; } rd_t;
    rd_t rd_q[$];

    function automatic logic [63:0] init_word(input logic [63:0] a);
        return {~a[31:0], a[31:0]};
    endfunction

    function automatic logic [63:0] rd_mem(input logic [63:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return init_word(a);
    endfunction

    function automatic logic [511:0] init_line(input logic [63:0] base);
        logic [511:0] l;
        for (int i = 0; i < 8; i++) l[i*64 +: 64] = init_word(base + 64'(i * 8));
        return l;
    endfunction

    always @(posedge clk) begin : model
        logic [63:0] w;
        if (mem_req && mem_rdy) begin
            if (mem_we) begin
                w = rd_mem(mem_addr);
                for (int b = 0; b < 8; b++)
                    if (mem_wstrb[b]) w[b*8 +: 8] = mem_wdat[b*8 +: 8];
                mem_model[mem_addr] = w;
            end else begin
                rd_q.push_back('{cyc + L, rd_mem(mem_addr)});
            end
        end
        cyc = cyc + 1;
        #1;
        model_v = 1'b0;
        model_d = '0;
        if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            model_v = 1'b1;
            model_d = rd_q[0].d;
            void'(rd_q.pop_front());
        end
    end

    // ---------------- beat scoreboard ----------------
    always @(negedge clk) begin
        if (!rst && mem_req && mem_rdy) begin
            if (exp_q.size() == 0) begin
                check("beat_pending", exp_q.size(), 1);
            end else begin
                check("beat", {mem_we, mem_wstrb, mem_addr}, exp_q.pop_front());
                if (mem_we) begin
                    if (exp_wd_q.size() == 0) check("beat_wdat_pending", exp_wd_q.size(), 1);
                    else check("beat_wdat", mem_wdat, exp_wd_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [7:0] id, input logic [63:0] strb,
                           input logic [63:0] addr, input logic [511:0] wdat);
        bus.s_rqst = id;
        bus.s_strb = strb;
        bus.s_addr = addr;
        bus.s_wdat = wdat;
    endtask

    task automatic push_reads(input logic [63:0] base);
        for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, 8'h00, base + 64'(i * 8)});
    endtask

    task automatic wait_done(input string tag, input int t0, input int exp_rel,
                             input logic [7:0] exp_h, input logic [511:0] exp_line);
        bit found = 1'b0;
        int n = 0;
        while (!found && n < 80) begin
            tick();
            @(negedge clk);
            n++;
            if (bus.s_resp[7]) found = 1'b1;
        end
        check({tag, "_seen"}, found, 1);
        if (found) begin
            if (exp_rel >= 0) check({tag, "_lat"}, cyc - t0, exp_rel);
            check({tag, "_handle"}, bus.s_resp, exp_h);
            check({tag, "_miss"}, bus.s_miss, 0);
            check({tag, "_rdat"}, bus.s_rdat, exp_line);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_s"}, {bus.s_resp, bus.s_miss}, 0);
        check({tag, "_rdat"}, bus.s_rdat, 0);
        check({tag, "_mem"}, {mem_req, mem_we, mem_wstrb, mem_addr, mem_wdat}, 0);
        check({tag, "_state"}, dbg.state, IDLE);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int t0;
        int t1;
        int ack_bad;
        int stall_bad;
        logic [511:0] line;
        logic [511:0] wd;

        rst     = 1'b1;
        mem_rdy = 1'b1;
        present(8'h00, '0, '0, '0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_quiet("reset");

        // Stray read data while idle must be ignored.
        tick(); inj_v = 1'b1; inj_d = 64'hDEAD_BEEF_0BAD_F00D;
        @(negedge clk);
        check_quiet("idle_rvalid");
        tick(); inj_v = 1'b0;
        @(negedge clk);
        check("idle_after_state", dbg.state, IDLE);

        // Read-only line.
        tick(); t0 = cyc;
        present(8'h05, '0, 64'h1040, '0);
        push_reads(64'h1040);
        @(negedge clk);
        check("rd_ack_resp", bus.s_resp, 8'h05);
        check("rd_ack_miss", bus.s_miss, 8'h80);
        tick(); present(8'h00, '0, '0, '0);
        @(negedge clk);
        check("rd_c1_state", dbg.state, IDLE);
        check("rd_c1_req", mem_req, 0);
        tick();
        @(negedge clk);
        check("rd_c2_state", dbg.state, READ);
        check("rd_c2_req", {mem_req, mem_addr}, {1'b1, 64'h1040});
        wait_done("rd", t0, 13, 8'h80, init_line(64'h1040));
        tick();
        @(negedge clk);
        check("rd_after_resp", bus.s_resp, 0);
        check("rd_after_rdat", bus.s_rdat, 0);

        // Single strobed beat (bytes 0-3), then merged read-back.
        tick(); t0 = cyc;
        wd = {{7{64'hCAFE_F00D_CAFE_F00D}}, 64'h1122_3344_5566_7788};
        present(8'h11, 64'h0F, 64'h2000, wd);
        exp_q.push_back({1'b1, 8'h0F, 64'h2000});
        exp_wd_q.push_back(64'h1122_3344_5566_7788);
        push_reads(64'h2000);
        @(negedge clk);
        check("wr_ack", {bus.s_resp, bus.s_miss}, {8'h11, 8'h80});
        tick(); present(8'h00, '0, '0, '0);
        line = init_line(64'h2000);
        line[31:0] = 32'h5566_7788;
        wait_done("wr", t0, 14, 8'h80, line);

        // Sparse strobes: beats 1 and 7 only, zero-strobe beats skipped.
        tick(); t0 = cyc;
        wd = {64'h1112_1314_1516_1718, {5{64'h5555_5555_5555_5555}},
              64'h0102_0304_0506_0708, 64'h5555_5555_5555_5555};
        present(8'h12, 64'hFF00_0000_0000_3000, 64'h2400, wd);
        exp_q.push_back({1'b1, 8'h30, 64'h2408});
        exp_wd_q.push_back(64'h0102_0304_0506_0708);
        exp_q.push_back({1'b1, 8'hFF, 64'h2438});
        exp_wd_q.push_back(64'h1112_1314_1516_1718);
        push_reads(64'h2400);
        @(negedge clk);
        check("wr2_ack", {bus.s_resp, bus.s_miss}, {8'h12, 8'h80});
        tick(); present(8'h00, '0, '0, '0);
        line = init_line(64'h2400);
        line[127:64]  = (init_word(64'h2408) & 64'hFFFF_0000_FFFF_FFFF) | 64'h0000_0304_0000_0000;
        line[511:448] = 64'h1112_1314_1516_1718;
        wait_done("wr2", t0, 15, 8'h80, line);

        // Queue full with memory stalled.
        tick(); mem_rdy = 1'b0; t0 = cyc;
        for (int id = 1; id <= 5; id++) begin
            if (id > 1) tick();
            present(8'(id), '0, 64'h3000 + 64'(id * 64), '0);
            push_reads(64'h3000 + 64'(id * 64));
            @(negedge clk);
            if (id < 5) begin
                check("full_ack_resp", bus.s_resp, 8'(id));
                check("full_ack_miss", bus.s_miss, 8'h80 | 8'(id - 1));
            end else begin
                check("full_id5_wait", bus.s_resp, 0);
            end
        end
        ack_bad = 0;
        stall_bad = 0;
        for (int r = 5; r <= 20; r++) begin
            tick();
            if (cyc - t0 == 10) mem_rdy = 1'b1;
            @(negedge clk);
            if (bus.s_resp != 8'd0) ack_bad++;
            if (cyc - t0 < 10 && !(mem_req && !mem_we && mem_addr == 64'h3040)) stall_bad++;
        end
        check("full_noack", ack_bad, 0);
        check("full_stall_hold", stall_bad, 0);
        wait_done("full_c0", t0, 21, 8'h80, init_line(64'h3040));
        tick();
        @(negedge clk);
        check("full_id5_ack", {bus.s_resp, bus.s_miss}, {8'h05, 8'h80});
        tick(); present(8'h00, '0, '0, '0);
        wait_done("full_c1", t0, -1, 8'h81, init_line(64'h3080));
        wait_done("full_c2", t0, -1, 8'h82, init_line(64'h30C0));
        wait_done("full_c3", t0, -1, 8'h83, init_line(64'h3100));
        wait_done("full_c4", t0, -1, 8'h80, init_line(64'h3140));

        // Request presented in the completion cycle.
        tick(); t0 = cyc;
        present(8'h21, '0, 64'h4000, '0);
        push_reads(64'h4000);
        @(negedge clk);
        check("col_ack1", {bus.s_resp, bus.s_miss}, {8'h21, 8'h80});
        tick(); present(8'h00, '0, '0, '0);
        while (cyc - t0 < 12) tick();
        tick();
        present(8'h22, '0, 64'h4040, '0);
        push_reads(64'h4040);
        @(negedge clk);
        check("col_resp_wins", {bus.s_resp, bus.s_miss}, {8'h80, 8'h00});
        check("col_resp_rdat", bus.s_rdat, init_line(64'h4000));
        tick();
        @(negedge clk);
        check("col_deferred_ack", {bus.s_resp, bus.s_miss}, {8'h22, 8'h80});
        t1 = cyc;
        tick(); present(8'h00, '0, '0, '0);
        wait_done("col2", t1, 13, 8'h80, init_line(64'h4040));

        // Reset in the middle of READ after three beats returned.
        tick(); t0 = cyc;
        present(8'h31, '0, 64'h5000, '0);
        push_reads(64'h5000);
        @(negedge clk);
        check("rst_ack", {bus.s_resp, bus.s_miss}, {8'h31, 8'h80});
        tick(); present(8'h00, '0, '0, '0);
        while (cyc - t0 < 8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        exp_wd_q.delete();
        @(negedge clk);
        check_quiet("rst_mid");
        tick();
        tick();
        @(negedge clk);
        check("rst_stale_state", dbg.state, IDLE);
        check("rst_stale_resp", bus.s_resp, 0);
        tick(); t1 = cyc;
        present(8'h32, '0, 64'h6000, '0);
        push_reads(64'h6000);
        @(negedge clk);
        check("rst_new_ack", {bus.s_resp, bus.s_miss}, {8'h32, 8'h80});
        tick(); present(8'h00, '0, '0, '0);
        wait_done("rst_new", t1, 13, 8'h80, init_line(64'h6000));

        tick();
        @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
